// File: rtl/sparc_exu_ccr_pipe.sv
// ECL condition-code pipe: forms icc/xcc from ALU flags in E, stages through M/W,
// commits per-thread CCRs and bypasses them to D. Optional parity: SPARC_EXU_CCR_PARITY_EN.
module sparc_exu_ccr_pipe #(
    parameter int NTHR = 4,
    parameter int TIDW = 2
) (
    input  logic              rclk,
    input  logic              arst_l,
    input  logic [TIDW-1:0]   ifu_exu_tid_e,
    input  logic              ecl_setcc_vld_e,
    input  logic              ecl_wrccr_vld_e,
    input  logic [7:0]        wrccr_data_e,
    input  logic              ecl_alu_out_sel_sum_e,
    input  logic              ecl_alu_sub_e,
    input  logic              alu_ecl_add_n64_e,
    input  logic              alu_ecl_add_n32_e,
    input  logic              alu_ecl_log_n64_e,
    input  logic              alu_ecl_log_n32_e,
    input  logic              alu_ecl_zhigh_e,
    input  logic              alu_ecl_zlow_e,
    input  logic              alu_ecl_adderin2_63_e,
    input  logic              alu_ecl_adderin2_31_e,
    input  logic              byp_alu_rs1_63_e,
    input  logic              byp_alu_rs1_31_e,
    input  logic              alu_ecl_cout64_e_l,
    input  logic              alu_ecl_cout32_e,
    input  logic              ecl_kill_m,
    input  logic              ecl_kill_w,
`ifdef SPARC_EXU_CCR_PARITY_EN
    input  logic              ecl_ccr_perr_inj,
    output logic              exu_ecl_ccr_perr_d,
`endif
    input  logic [TIDW-1:0]   ifu_exu_tid_d,
    output logic [7:0]        exu_ifu_ccr_d,
    output logic [8*NTHR-1:0] exu_ccr_thr
);

    logic            n64, n32, z64, z32, v64, v32, c64, c32;
    logic            vld_e;
    logic [7:0]      ccr_e;
    logic            vld_m, vld_w;
    logic [TIDW-1:0] tid_m, tid_w;
    logic [7:0]      ccr_m, ccr_w;
    logic [7:0]      ccr_arch [NTHR];
    logic            e_hit, m_hit, w_hit;
`ifdef SPARC_EXU_CCR_PARITY_EN
    logic [NTHR-1:0] par_arch;
`endif

    assign vld_e = ecl_setcc_vld_e | ecl_wrccr_vld_e;

    always_comb begin
        n64 = ecl_alu_out_sel_sum_e ? alu_ecl_add_n64_e : alu_ecl_log_n64_e;
        n32 = ecl_alu_out_sel_sum_e ? alu_ecl_add_n32_e : alu_ecl_log_n32_e;
        z32 = alu_ecl_zlow_e;
        z64 = alu_ecl_zlow_e & alu_ecl_zhigh_e;
        v64 = 1'b0;
        v32 = 1'b0;
        c64 = 1'b0;
        c32 = 1'b0;
        if (ecl_alu_out_sel_sum_e) begin
            v64 = (byp_alu_rs1_63_e & alu_ecl_adderin2_63_e & ~n64) |
                  (~byp_alu_rs1_63_e & ~alu_ecl_adderin2_63_e & n64);
            v32 = (byp_alu_rs1_31_e & alu_ecl_adderin2_31_e & ~n32) |
                  (~byp_alu_rs1_31_e & ~alu_ecl_adderin2_31_e & n32);
            // Subtract reports borrow, the complement of the adder carry.
            c64 = ~alu_ecl_cout64_e_l ^ ecl_alu_sub_e;
            c32 = alu_ecl_cout32_e ^ ecl_alu_sub_e;
        end
        ccr_e = ecl_wrccr_vld_e ? wrccr_data_e : {n64, z64, v64, c64, n32, z32, v32, c32};
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            vld_m <= 1'b0;
            tid_m <= '0;
            ccr_m <= 8'h00;
            vld_w <= 1'b0;
            tid_w <= '0;
            ccr_w <= 8'h00;
            for (int i = 0; i < NTHR; i++) ccr_arch[i] <= 8'h00;
`ifdef SPARC_EXU_CCR_PARITY_EN
            par_arch <= '0;
`endif
        end else begin
            vld_m <= vld_e;
            tid_m <= ifu_exu_tid_e;
            ccr_m <= ccr_e;
            vld_w <= vld_m & ~ecl_kill_m;
            tid_w <= tid_m;
            ccr_w <= ccr_m;
            if (vld_w && !ecl_kill_w) begin
                ccr_arch[tid_w] <= ccr_w;
`ifdef SPARC_EXU_CCR_PARITY_EN
                par_arch[tid_w] <= (^ccr_w) ^ ecl_ccr_perr_inj;
`endif
            end
        end
    end

    // Newest matching in-flight value wins over the architectural copy.
    assign e_hit = vld_e && (ifu_exu_tid_e == ifu_exu_tid_d);
    assign m_hit = vld_m && !ecl_kill_m && (tid_m == ifu_exu_tid_d);
    assign w_hit = vld_w && !ecl_kill_w && (tid_w == ifu_exu_tid_d);

    always_comb begin
        if (e_hit)      exu_ifu_ccr_d = ccr_e;
        else if (m_hit) exu_ifu_ccr_d = ccr_m;
        else if (w_hit) exu_ifu_ccr_d = ccr_w;
        else            exu_ifu_ccr_d = ccr_arch[ifu_exu_tid_d];
    end

`ifdef SPARC_EXU_CCR_PARITY_EN
    assign exu_ecl_ccr_perr_d = ~(e_hit | m_hit | w_hit) &
                                ((^ccr_arch[ifu_exu_tid_d]) ^ par_arch[ifu_exu_tid_d]);
`endif

    for (genvar i = 0; i < NTHR; i++) begin : g_thr
        assign exu_ccr_thr[8*i +: 8] = ccr_arch[i];
    end

endmodule

// File: tb/tb_sparc_exu_ccr_pipe.sv
// Bench for sparc_exu_ccr_pipe: operands are chosen as 64-bit numbers, flags are
// derived from plain arithmetic, and a small in-flight list models the pipe.
module tb_sparc_exu_ccr_pipe;

    localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_XOR = 4;

    logic        rclk = 1'b0;
    logic        arst_l;
    logic [1:0]  ifu_exu_tid_e, ifu_exu_tid_d;
    logic        ecl_setcc_vld_e, ecl_wrccr_vld_e;
    logic [7:0]  wrccr_data_e;
    logic        ecl_alu_out_sel_sum_e, ecl_alu_sub_e;
    logic        alu_ecl_add_n64_e, alu_ecl_add_n32_e, alu_ecl_log_n64_e, alu_ecl_log_n32_e;
    logic        alu_ecl_zhigh_e, alu_ecl_zlow_e;
    logic        alu_ecl_adderin2_63_e, alu_ecl_adderin2_31_e, byp_alu_rs1_63_e, byp_alu_rs1_31_e;
    logic        alu_ecl_cout64_e_l, alu_ecl_cout32_e;
    logic        ecl_kill_m, ecl_kill_w;
    logic [7:0]  exu_ifu_ccr_d;
    logic [31:0] exu_ccr_thr;
    logic        ecl_ccr_perr_inj;
`ifdef SPARC_EXU_CCR_PARITY_EN
    logic        exu_ecl_ccr_perr_d;
`endif

    sparc_exu_ccr_pipe #(.NTHR(4), .TIDW(2)) dut (
        .rclk(rclk), .arst_l(arst_l),
        .ifu_exu_tid_e(ifu_exu_tid_e),
        .ecl_setcc_vld_e(ecl_setcc_vld_e), .ecl_wrccr_vld_e(ecl_wrccr_vld_e),
        .wrccr_data_e(wrccr_data_e),
        .ecl_alu_out_sel_sum_e(ecl_alu_out_sel_sum_e), .ecl_alu_sub_e(ecl_alu_sub_e),
        .alu_ecl_add_n64_e(alu_ecl_add_n64_e), .alu_ecl_add_n32_e(alu_ecl_add_n32_e),
        .alu_ecl_log_n64_e(alu_ecl_log_n64_e), .alu_ecl_log_n32_e(alu_ecl_log_n32_e),
        .alu_ecl_zhigh_e(alu_ecl_zhigh_e), .alu_ecl_zlow_e(alu_ecl_zlow_e),
        .alu_ecl_adderin2_63_e(alu_ecl_adderin2_63_e), .alu_ecl_adderin2_31_e(alu_ecl_adderin2_31_e),
        .byp_alu_rs1_63_e(byp_alu_rs1_63_e), .byp_alu_rs1_31_e(byp_alu_rs1_31_e),
        .alu_ecl_cout64_e_l(alu_ecl_cout64_e_l), .alu_ecl_cout32_e(alu_ecl_cout32_e),
        .ecl_kill_m(ecl_kill_m), .ecl_kill_w(ecl_kill_w),
`ifdef SPARC_EXU_CCR_PARITY_EN
        .ecl_ccr_perr_inj(ecl_ccr_perr_inj), .exu_ecl_ccr_perr_d(exu_ecl_ccr_perr_d),
`endif
        .ifu_exu_tid_d(ifu_exu_tid_d),
        .exu_ifu_ccr_d(exu_ifu_ccr_d), .exu_ccr_thr(exu_ccr_thr)
    );

    always #5 rclk = ~rclk;

    typedef struct packed {
        logic       vld;
        logic [1:0] tid;
        logic [7:0] ccr;
    } slot_t;

    slot_t      cur;          // instruction presented in E this cycle
    slot_t      slot_q[$];    // [0] = one cycle old, [1] = two cycles old
    logic [7:0] arch [4];
    logic [3:0] bad_par;
    int         n_assert = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        slot_q = {};
        slot_q.push_back(slot_t'(0));
        slot_q.push_back(slot_t'(0));
        for (int i = 0; i < 4; i++) arch[i] = 8'h00;
        bad_par = 4'h0;
    endtask

    // Drive the ALU-side signals for op(a,b) and record the expected E value.
    task automatic set_e(input int op, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] tid, input logic setcc, input logic wrccr,
                         input logic [7:0] wdata);
        logic [63:0] r, in2;
        logic [64:0] s65;
        logic [32:0] s33;
        logic signed [65:0] w64;
        logic signed [33:0] w32;
        logic v64, v32, c64, c32, adder;
        adder = (op == OP_ADD) || (op == OP_SUB);
        v64 = 1'b0; v32 = 1'b0; c64 = 1'b0; c32 = 1'b0;
        in2 = {$urandom, $urandom};
        s65 = {1'b0, in2} ^ {1'b0, a};
        s33 = s65[32:0];
        case (op)
            OP_ADD: begin
                r = a + b; in2 = b;
                s65 = {1'b0, a} + {1'b0, b};
                s33 = {1'b0, a[31:0]} + {1'b0, b[31:0]};
                w64 = {{2{a[63]}}, a} + {{2{b[63]}}, b};
                w32 = {{2{a[31]}}, a[31:0]} + {{2{b[31]}}, b[31:0]};
                v64 = w64[64] ^ w64[63];
                v32 = w32[32] ^ w32[31];
                c64 = (r < a);
                c32 = (r[31:0] < a[31:0]);
            end
            OP_SUB: begin
                r = a - b; in2 = ~b;
                s65 = {1'b0, a} + {1'b0, ~b} + 65'd1;
                s33 = {1'b0, a[31:0]} + {1'b0, ~b[31:0]} + 33'd1;
                w64 = {{2{a[63]}}, a} - {{2{b[63]}}, b};
                w32 = {{2{a[31]}}, a[31:0]} - {{2{b[31]}}, b[31:0]};
                v64 = w64[64] ^ w64[63];
                v32 = w32[32] ^ w32[31];
                c64 = (a < b);
                c32 = (a[31:0] < b[31:0]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = a ^ b;
        endcase
        ifu_exu_tid_e         = tid;
        ecl_setcc_vld_e       = setcc;
        ecl_wrccr_vld_e       = wrccr;
        wrccr_data_e          = wdata;
        ecl_alu_out_sel_sum_e = adder;
        ecl_alu_sub_e         = adder ? (op == OP_SUB) : 1'($urandom_range(0, 1));
        alu_ecl_add_n64_e     = adder ? r[63] : 1'($urandom_range(0, 1));
        alu_ecl_add_n32_e     = adder ? r[31] : 1'($urandom_range(0, 1));
        alu_ecl_log_n64_e     = adder ? 1'($urandom_range(0, 1)) : r[63];
        alu_ecl_log_n32_e     = adder ? 1'($urandom_range(0, 1)) : r[31];
        alu_ecl_zhigh_e       = (r[63:32] == 32'h0);
        alu_ecl_zlow_e        = (r[31:0] == 32'h0);
        alu_ecl_adderin2_63_e = in2[63];
        alu_ecl_adderin2_31_e = in2[31];
        byp_alu_rs1_63_e      = a[63];
        byp_alu_rs1_31_e      = a[31];
        alu_ecl_cout64_e_l    = ~s65[64];
        alu_ecl_cout32_e      = s33[32];
        cur.vld = setcc | wrccr;
        cur.tid = tid;
        cur.ccr = wrccr ? wdata : {r[63], r == 64'h0, v64, c64, r[31], r[31:0] == 32'h0, v32, c32};
    endtask

    task automatic set_idle();
        set_e(OP_AND, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
              1'b0, 1'b0, 8'($urandom));
    endtask

    // One pipe cycle: check D read / arch CCRs, clock the DUT, advance the model.
    task automatic cycle(input logic [1:0] td, input logic km, input logic kw);
        logic [7:0] exp_d;
        logic       hit;
        ifu_exu_tid_d = td;
        ecl_kill_m    = km;
        ecl_kill_w    = kw;
        #1;
        hit = 1'b1;
        if (cur.vld && cur.tid == td)                            exp_d = cur.ccr;
        else if (slot_q[0].vld && !km && slot_q[0].tid == td)    exp_d = slot_q[0].ccr;
        else if (slot_q[1].vld && !kw && slot_q[1].tid == td)    exp_d = slot_q[1].ccr;
        else begin exp_d = arch[td]; hit = 1'b0; end
        chk("ccr_d", {24'h0, exu_ifu_ccr_d}, {24'h0, exp_d});
        chk("ccr_thr", exu_ccr_thr, {arch[3], arch[2], arch[1], arch[0]});
`ifdef SPARC_EXU_CCR_PARITY_EN
        chk("perr_d", {31'h0, exu_ecl_ccr_perr_d}, {31'h0, ~hit & bad_par[td]});
`endif
        @(posedge rclk);
        if (slot_q[1].vld && !kw) begin
            arch[slot_q[1].tid] = slot_q[1].ccr;
            bad_par[slot_q[1].tid] = ecl_ccr_perr_inj;
        end
        void'(slot_q.pop_back());
        slot_q[0].vld = slot_q[0].vld & ~km;
        slot_q.push_front(cur);
        @(negedge rclk);
    endtask

    task automatic check_reset_all(input string tag);
        for (int t = 0; t < 4; t++) begin
            ifu_exu_tid_d = 2'(t);
            #1;
            chk({tag, "_ccr_d"}, {24'h0, exu_ifu_ccr_d}, 32'h0);
            chk({tag, "_thr"}, exu_ccr_thr, 32'h0);
        end
    endtask

    initial begin
        arst_l = 1'b0;
        ecl_kill_m = 1'b0;
        ecl_kill_w = 1'b0;
        ecl_ccr_perr_inj = 1'b0;
        ifu_exu_tid_d = 2'd0;
        set_idle();
        model_clear();
        @(negedge rclk);
        check_reset_all("reset");
        @(negedge rclk);
        arst_l = 1'b1;

        // 32-bit signed overflow on thread 1.
        set_e(OP_ADD, 64'h7FFF_FFFF, 64'h1, 2'd1, 1'b1, 1'b0, 8'h00);
        cycle(2'd1, 1'b0, 1'b0);
        set_idle(); cycle(2'd1, 1'b0, 1'b0);
        set_idle(); cycle(2'd1, 1'b0, 1'b0);
        chk("add_ovf_thr1", {24'h0, exu_ccr_thr[15:8]}, 32'h0A);

        // 5 - 5 on thread 2, read back through the M bypass.
        set_e(OP_SUB, 64'd5, 64'd5, 2'd2, 1'b1, 1'b0, 8'h00);
        cycle(2'd2, 1'b0, 1'b0);
        set_idle();
        ifu_exu_tid_d = 2'd2;
        #1;
        chk("sub_byp_m", {24'h0, exu_ifu_ccr_d}, 32'h44);
        cycle(2'd2, 1'b0, 1'b0);
        set_idle(); cycle(2'd2, 1'b0, 1'b0);
        chk("sub_thr2", {24'h0, exu_ccr_thr[23:16]}, 32'h44);

        // Killed in M on thread 0: never commits.
        set_e(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'd0, 1'b1, 1'b0, 8'h00);
        cycle(2'd0, 1'b0, 1'b0);
        set_idle(); cycle(2'd0, 1'b1, 1'b0);
        set_idle(); cycle(2'd0, 1'b0, 1'b0);
        set_idle(); cycle(2'd0, 1'b0, 1'b0);
        chk("kill_m_thr0", {24'h0, exu_ccr_thr[7:0]}, 32'h0);

        // WRCCR beats setcc; then a zero logic result overrides it.
        set_e(OP_ADD, {$urandom, $urandom}, {$urandom, $urandom}, 2'd3, 1'b1, 1'b1, 8'hFF);
        cycle(2'd3, 1'b0, 1'b0);
        set_idle(); cycle(2'd3, 1'b0, 1'b0);
        set_idle(); cycle(2'd3, 1'b0, 1'b0);
        chk("wrccr_thr3", {24'h0, exu_ccr_thr[31:24]}, 32'hFF);
        set_e(OP_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 2'd3, 1'b1, 1'b0, 8'h00);
        ifu_exu_tid_d = 2'd3;
        #1;
        chk("logic_byp_e", {24'h0, exu_ifu_ccr_d}, 32'h44);
        cycle(2'd3, 1'b0, 1'b0);
        set_idle(); cycle(2'd3, 1'b0, 1'b0);
        set_idle(); cycle(2'd3, 1'b0, 1'b0);
        chk("logic_thr3", {24'h0, exu_ccr_thr[31:24]}, 32'h44);

        // Back-to-back on thread 1, with a W kill and both kills together.
        set_e(OP_SUB, 64'd1, 64'd2, 2'd1, 1'b1, 1'b0, 8'h00); cycle(2'd1, 1'b0, 1'b0);
        set_e(OP_ADD, 64'd3, 64'd4, 2'd1, 1'b1, 1'b0, 8'h00); cycle(2'd1, 1'b0, 1'b0);
        set_e(OP_OR, 64'h8000_0000_0000_0000, 64'd0, 2'd1, 1'b1, 1'b0, 8'h00); cycle(2'd1, 1'b0, 1'b1);
        set_idle(); cycle(2'd1, 1'b1, 1'b1);
        set_idle(); cycle(2'd1, 1'b0, 1'b0);

`ifdef SPARC_EXU_CCR_PARITY_EN
        set_e(OP_ADD, 64'd1, 64'd1, 2'd0, 1'b1, 1'b0, 8'h00); cycle(2'd1, 1'b0, 1'b0);
        set_idle(); cycle(2'd1, 1'b0, 1'b0);
        set_idle(); ecl_ccr_perr_inj = 1'b1; cycle(2'd1, 1'b0, 1'b0);
        ecl_ccr_perr_inj = 1'b0;
        for (int t = 0; t < 4; t++) begin
            ifu_exu_tid_d = 2'(t);
            #1;
            chk("perr_inj", {31'h0, exu_ecl_ccr_perr_d}, {31'h0, t == 0});
        end
        @(negedge rclk);
`endif

        // Asynchronous reset with three instructions in flight.
        set_e(OP_ADD, 64'd7, 64'd9, 2'd2, 1'b1, 1'b0, 8'h00); cycle(2'd0, 1'b0, 1'b0);
        set_e(OP_SUB, 64'd7, 64'd9, 2'd2, 1'b1, 1'b0, 8'h00); cycle(2'd0, 1'b0, 1'b0);
        set_e(OP_XOR, 64'd7, 64'd9, 2'd1, 1'b1, 1'b0, 8'h00);
        arst_l = 1'b0;
        set_idle();
        model_clear();
        check_reset_all("midreset");
        @(negedge rclk);
        arst_l = 1'b1;
        set_idle(); cycle(2'd2, 1'b0, 1'b0);
        set_idle(); cycle(2'd2, 1'b0, 1'b0);
        set_idle(); cycle(2'd2, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [63:0] a, b;
            int op;
            op = $urandom_range(0, 4);
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = {$urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0, 32'h7FFF_FFFF};
                default: b = {$urandom, $urandom};
            endcase
            set_e(op, a, b, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 5) == 0), 8'($urandom));
            ecl_ccr_perr_inj = ($urandom_range(0, 9) == 0);
            cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
